// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package sfifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : sfifo_pkg

// File: rtl/sfifo_param_mem.sv
// Storage array for sfifo_param: one synchronous write port, one registered read port.
// The array itself is not reset; only the read-data register is.
module sfifo_param_mem
  import sfifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: capture the addressed word on an accepted read, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : sfifo_param_mem

// File: rtl/sfifo_param.sv
// Parameterised synchronous FIFO: pointers, occupancy count, status flags.
// Optional sticky overflow/underflow detection is built when SFIFO_ERR_EN is defined.
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic                   read_enable,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          rd_acc, wr_acc;

  // Full/empty from pointer equality and wrap-bit comparison.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // Accept logic; a write into a full FIFO is allowed when a read frees a slot.
  assign rd_acc = read_enable & ~empty;
  assign wr_acc = write_enable & (~full | rd_acc);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sfifo_param_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (data_out)
  );

`ifdef SFIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error next-state: set on any rejected request.
  always_comb begin
    ovf_d = ovf_q | (write_enable & ~wr_acc);
    unf_d = unf_q | (read_enable & ~rd_acc);
  end

  // Sticky error registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule : sfifo_param

// File: tb/tb_sfifo_param.sv
// Directed, table-driven bench for sfifo_param at WIDTH=8, DEPTH=8, default levels.
module tb_sfifo_param;

`ifdef SFIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  sfifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Expected record; flags follow directly from their definitions (DEPTH=8, AF=6, AE=2).
  function automatic vec_t mk(input logic we, input logic re, input logic [7:0] din,
                              input logic [7:0] dout, input logic [3:0] cnt,
                              input logic ovf, input logic unf);
    vec_t v;
    v.we = we; v.re = re; v.din = din; v.dout = dout; v.cnt = cnt;
    v.full  = (cnt == 4'd8);
    v.empty = (cnt == 4'd0);
    v.af    = (cnt >= 4'd6);
    v.ae    = (cnt <= 4'd2);
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " data_out"},     64'(data_out),     64'(v.dout));
    chk({tag, " count"},        64'(count),        64'(v.cnt));
    chk({tag, " full"},         64'(full),         64'(v.full));
    chk({tag, " empty"},        64'(empty),        64'(v.empty));
    chk({tag, " almost_full"},  64'(almost_full),  64'(v.af));
    chk({tag, " almost_empty"}, 64'(almost_empty), 64'(v.ae));
    chk({tag, " overflow"},     64'(overflow),     64'(v.ovf));
    chk({tag, " underflow"},    64'(underflow),    64'(v.unf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wd [8];
    vec_t       v;
    wd = '{8'd1, 8'd9, 8'd7, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10};

    // Fill 8 words; full and count 8 after the 8th edge.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b1, 1'b0, wd[i], 8'd0, 4'(i + 1), 1'b0, 1'b0));
    // Write to full FIFO without read: rejected.
    tbl.push_back(mk(1'b1, 1'b0, 8'd23, 8'd0, 4'd8, ERR, 1'b0));
    // Drain in order, then one rejected read that holds data_out.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 1'b1, 8'd0, wd[i], 4'(7 - i), ERR, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'd0, 8'd10, 4'd0, ERR, ERR));
    // Empty FIFO read+write: write only, no bypass; then read it out.
    tbl.push_back(mk(1'b1, 1'b1, 8'd5, 8'd10, 4'd1, ERR, ERR));
    tbl.push_back(mk(1'b0, 1'b1, 8'd0, 8'd5, 4'd0, ERR, ERR));
    // Bring count to 4, then 20 simultaneous read+write cycles across the wrap.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, 1'b0, 8'(11 + i), 8'd5, 4'(i + 1), ERR, ERR));
    for (int k = 0; k < 20; k++) tbl.push_back(mk(1'b1, 1'b1, 8'(15 + k), 8'(11 + k), 4'd4, ERR, ERR));
    // FIFO now holds 31..34; fill to full with 35..38.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, 1'b0, 8'(35 + i), 8'd30, 4'(5 + i), ERR, ERR));
    // Full FIFO read+write: both accepted, oldest word out, still full.
    tbl.push_back(mk(1'b1, 1'b1, 8'd39, 8'd31, 4'd8, ERR, ERR));
    // Read down to count 5.
    tbl.push_back(mk(1'b0, 1'b1, 8'd0, 8'd32, 4'd7, ERR, ERR));
    tbl.push_back(mk(1'b0, 1'b1, 8'd0, 8'd33, 4'd6, ERR, ERR));
    tbl.push_back(mk(1'b0, 1'b1, 8'd0, 8'd34, 4'd5, ERR, ERR));

    // Reset state.
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; data_in = 8'h00;
    #12;
    chk_all("reset", mk(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // Apply the table.
    foreach (tbl[i]) begin
      @(negedge clk);
      write_enable = tbl[i].we;
      read_enable  = tbl[i].re;
      data_in      = tbl[i].din;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset mid-cycle with 5 words stored.
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", mk(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // First write after reset is the next word read.
    write_enable = 1'b1; data_in = 8'd42;
    @(posedge clk);
    #1;
    chk_all("post_reset_wr", mk(1'b0, 1'b0, 8'd0, 8'd0, 4'd1, 1'b0, 1'b0));
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_rd", mk(1'b0, 1'b0, 8'd0, 8'd42, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    read_enable = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle_hold", mk(1'b0, 1'b0, 8'd0, 8'd42, 4'd0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_sfifo_param
